// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache line refill sequencer: block geometry,
// FSM state encoding and address-split helpers.
package cache_refill_ctrl_pkg;

  localparam int unsigned OFFSET_W        = 3;
  localparam int unsigned WORDS_PER_BLOCK = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } refill_state_e;

  // Helpers work on a zero-extended 32-bit address; callers size-cast the result.
  function automatic logic [31:0] addr_offset(input logic [31:0] addr);
    return addr & (WORDS_PER_BLOCK - 1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned index_w);
    return (addr >> OFFSET_W) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned index_w);
    return addr >> (OFFSET_W + index_w);
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_counter.sv
// Word position tracker for a refill: wrapping block offset plus a count of
// words already written.
module cache_refill_ctrl_counter
  import cache_refill_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [OFFSET_W-1:0] load_off,
  input  logic                inc,
  output logic [OFFSET_W-1:0] cur_off,
  output logic [OFFSET_W-1:0] cnt,
  output logic                last
);

  logic [OFFSET_W-1:0] cur_off_q, cur_off_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cur_off_d = cur_off_q;
    cnt_d     = cnt_q;
    if (load) begin
      cur_off_d = load_off;
      cnt_d     = '0;
    end else if (inc) begin
      // Offset width equals log2 of the block size, so natural overflow wraps 7 -> 0.
      cur_off_d = cur_off_q + OFFSET_W'(1);
      cnt_d     = cnt_q + OFFSET_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_off_q <= '0;
      cnt_q     <= '0;
    end else begin
      cur_off_q <= cur_off_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cur_off = cur_off_q;
  assign cnt     = cnt_q;
  assign last    = (cnt_q == OFFSET_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill sequencer: fetches an 8-word block critical-word-first
// with wrap-around, writes each word, then writes tag/valid and pulses done.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned INDEX_W = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             miss_req,
  input  logic [ADDR_W-1:0]                miss_addr,
  output logic                             mem_req,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_valid,
  input  logic [DATA_W-1:0]                mem_data,
  output logic                             fill_we,
  output logic [OFFSET_W-1:0]              fill_offset,
  output logic [INDEX_W-1:0]               fill_index,
  output logic [DATA_W-1:0]                fill_data,
  output logic                             fill_tag_we,
  output logic [ADDR_W-OFFSET_W-INDEX_W-1:0] fill_tag,
  output logic                             crit_ready,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned TAG_W = ADDR_W - OFFSET_W - INDEX_W;

  refill_state_e state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                ctr_load, ctr_inc, ctr_last;
  logic [OFFSET_W-1:0] ctr_load_off, cur_off, cnt;

  cache_refill_ctrl_counter u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_off (ctr_load_off),
    .inc      (ctr_inc),
    .cur_off  (cur_off),
    .cnt      (cnt),
    .last     (ctr_last)
  );

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    index_d      = index_q;
    data_d       = data_q;
    ctr_load     = 1'b0;
    ctr_inc      = 1'b0;
    ctr_load_off = OFFSET_W'(addr_offset(32'(miss_addr)));
    mem_req      = 1'b0;
    mem_addr     = '0;
    fill_we      = 1'b0;
    fill_offset  = '0;
    fill_index   = '0;
    fill_data    = '0;
    fill_tag_we  = 1'b0;
    fill_tag     = '0;
    crit_ready   = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          tag_d    = TAG_W'(addr_tag(32'(miss_addr), INDEX_W));
          index_d  = INDEX_W'(addr_index(32'(miss_addr), INDEX_W));
          ctr_load = 1'b1;
          state_d  = FILL;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag_q, index_q, cur_off};
        if (mem_valid) begin
          data_d  = mem_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        fill_we     = 1'b1;
        fill_data   = data_q;
        fill_offset = cur_off;
        fill_index  = index_q;
        crit_ready  = (cnt == '0);
        ctr_inc     = 1'b1;
        state_d     = ctr_last ? DONE : FILL;
      end
      DONE: begin
        fill_tag_we = 1'b1;
        done        = 1'b1;
        fill_tag    = tag_q;
        fill_index  = index_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: table of refill scenarios plus
// hand-written sequences for ignored inputs, mid-refill reset and back-to-back misses.
module tb_cache_refill_ctrl;

  logic        clk;
  logic        rst;
  logic        miss_req;
  logic [15:0] miss_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        fill_we;
  logic [2:0]  fill_offset;
  logic [3:0]  fill_index;
  logic [15:0] fill_data;
  logic        fill_tag_we;
  logic [8:0]  fill_tag;
  logic        crit_ready;
  logic        busy;
  logic        done;

  int unsigned errors;
  int unsigned checks;

  cache_refill_ctrl #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .INDEX_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .miss_req    (miss_req),
    .miss_addr   (miss_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_valid   (mem_valid),
    .mem_data    (mem_data),
    .fill_we     (fill_we),
    .fill_offset (fill_offset),
    .fill_index  (fill_index),
    .fill_data   (fill_data),
    .fill_tag_we (fill_tag_we),
    .fill_tag    (fill_tag),
    .crit_ready  (crit_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] addr;
    int          lat;     // -1 selects a random 0..5 cycle latency per word
    logic [15:0] base;
    logic [2:0]  start;
    logic [3:0]  idx;
    logic [8:0]  tag;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"},        32'(busy),        0);
    chk({name, "_mem_req"},     32'(mem_req),     0);
    chk({name, "_mem_addr"},    32'(mem_addr),    0);
    chk({name, "_fill_we"},     32'(fill_we),     0);
    chk({name, "_fill_offset"}, 32'(fill_offset), 0);
    chk({name, "_fill_index"},  32'(fill_index),  0);
    chk({name, "_fill_data"},   32'(fill_data),   0);
    chk({name, "_fill_tag_we"}, 32'(fill_tag_we), 0);
    chk({name, "_fill_tag"},    32'(fill_tag),    0);
    chk({name, "_crit_ready"},  32'(crit_ready),  0);
    chk({name, "_done"},        32'(done),        0);
  endtask

  // Runs one complete refill from IDLE in lockstep with the expected schedule.
  task automatic do_refill(input logic [15:0] addr, input int lat, input logic [15:0] base,
                           input logic [2:0] start, input logic [3:0] idx, input logic [8:0] tag,
                           input bit noise, input bit hold, input logic [15:0] next_addr);
    int unsigned c;
    int unsigned total;
    int unsigned l;
    logic [2:0]  eo;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;

    miss_addr = addr;
    miss_req  = 1'b1;
    mem_valid = 1'b0;
    tick();
    c = 1;
    total = 0;
    if (!hold) miss_req = 1'b0;
    chk("busy_rise", 32'(busy), 1);

    for (int unsigned w = 0; w < 8; w++) begin
      eo       = start + 3'(w);
      exp_addr = {addr[15:3], eo};
      exp_data = base + 16'(eo);
      l        = (lat < 0) ? $urandom_range(5, 0) : int'(lat);
      total   += l;
      if (noise && w == 2) begin
        miss_req  = 1'b1;
        miss_addr = 16'h0FF0;
      end
      for (int unsigned k = 0; k <= l; k++) begin
        mem_valid = (k == l);
        mem_data  = (k == l) ? exp_data : 16'hBEEF;
        chk("fill_mem_req",  32'(mem_req),  1);
        chk("fill_mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("fill_no_we",    32'(fill_we),  0);
        tick();
        c++;
      end
      mem_valid = noise;
      mem_data  = 16'hDEAD;
      chk("wr_we",     32'(fill_we),     1);
      chk("wr_mem_req",32'(mem_req),     0);
      chk("wr_offset", 32'(fill_offset), 32'(eo));
      chk("wr_index",  32'(fill_index),  32'(idx));
      chk("wr_data",   32'(fill_data),   32'(exp_data));
      chk("wr_crit",   32'(crit_ready),  (w == 0) ? 1 : 0);
      chk("wr_done",   32'(done),        0);
      tick();
      c++;
      mem_valid = 1'b0;
    end

    if (noise) begin
      miss_req  = 1'b0;
      mem_valid = 1'b1;
    end
    if (hold) miss_addr = next_addr;
    chk("done_pulse",   32'(done),        1);
    chk("done_tag_we",  32'(fill_tag_we), 1);
    chk("done_tag",     32'(fill_tag),    32'(tag));
    chk("done_index",   32'(fill_index),  32'(idx));
    chk("done_no_we",   32'(fill_we),     0);
    chk("done_mem_req", 32'(mem_req),     0);
    chk("done_cycle",   c,                17 + total);
    tick();
    mem_valid = 1'b0;
    chk("post_busy",   32'(busy),        0);
    chk("post_done",   32'(done),        0);
    chk("post_tag_we", 32'(fill_tag_we), 0);
  endtask

  initial begin
    int unsigned wcount;

    vecs[0] = '{addr: 16'h1230, lat: 1,  base: 16'h5000, start: 3'd0, idx: 4'h6, tag: 9'h024};
    vecs[1] = '{addr: 16'h1235, lat: 0,  base: 16'h6000, start: 3'd5, idx: 4'h6, tag: 9'h024};
    vecs[2] = '{addr: 16'h3007, lat: 2,  base: 16'h7000, start: 3'd7, idx: 4'h0, tag: 9'h060};
    vecs[3] = '{addr: 16'hFFFF, lat: 0,  base: 16'h8000, start: 3'd7, idx: 4'hF, tag: 9'h1FF};
    vecs[4] = '{addr: 16'h0008, lat: 3,  base: 16'h9000, start: 3'd0, idx: 4'h1, tag: 9'h000};
    vecs[5] = '{addr: 16'hA5C3, lat: -1, base: 16'hA000, start: 3'd3, idx: 4'h8, tag: 9'h14B};

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    miss_req  = 1'b0;
    miss_addr = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("idle");

    for (int unsigned i = 0; i < 6; i++) begin
      do_refill(vecs[i].addr, vecs[i].lat, vecs[i].base, vecs[i].start,
                vecs[i].idx, vecs[i].tag, 1'b0, 1'b0, 16'h0000);
    end

    // Mid-fill miss_req and spurious mem_valid in WRITE/DONE must not disturb the refill.
    do_refill(16'h1230, 1, 16'hC000, 3'd0, 4'h6, 9'h024, 1'b1, 1'b0, 16'h0000);
    mem_valid = 1'b1;
    mem_data  = 16'h5555;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("idle_spur_busy",    32'(busy),    0);
      chk("idle_spur_we",      32'(fill_we), 0);
      chk("idle_spur_mem_req", 32'(mem_req), 0);
    end
    mem_valid = 1'b0;

    // Reset after three words; miss_req coincident with rst is ignored.
    miss_addr = 16'h1230;
    miss_req  = 1'b1;
    tick();
    miss_req = 1'b0;
    wcount   = 0;
    for (int unsigned w = 0; w < 3; w++) begin
      mem_valid = 1'b0;
      tick();
      mem_valid = 1'b1;
      mem_data  = 16'h3000 + 16'(w);
      tick();
      mem_valid = 1'b0;
      if (fill_we) wcount++;
      tick();
    end
    chk("rst_prefix_writes", wcount, 3);
    chk("rst_prefix_in_fill", 32'(mem_req), 1);
    rst       = 1'b1;
    miss_req  = 1'b1;
    miss_addr = 16'h4444;
    tick();
    rst      = 1'b0;
    miss_req = 1'b0;
    chk_all_zero("after_rst");
    mem_valid = 1'b1;
    mem_data  = 16'h1111;
    for (int unsigned i = 0; i < 2; i++) begin
      tick();
      chk("late_valid_busy", 32'(busy),        0);
      chk("late_valid_we",   32'(fill_we),     0);
      chk("late_valid_done", 32'(done),        0);
      chk("late_valid_tag",  32'(fill_tag_we), 0);
    end
    mem_valid = 1'b0;
    do_refill(16'h2000, 1, 16'h2100, 3'd0, 4'h0, 9'h040, 1'b0, 1'b0, 16'h0000);

    // Back-to-back: miss_req held high, address switched during DONE.
    do_refill(16'h1230, 0, 16'h4000, 3'd0, 4'h6, 9'h024, 1'b0, 1'b1, 16'h3007);
    do_refill(16'h3007, 0, 16'h4100, 3'd7, 4'h0, 9'h060, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("final_idle_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
